// File: rtl/modexp_stream_ctrl_if.sv
// rtl/modexp_stream_ctrl_if.sv - host operand/result and core word-stream signals of the ModExp sequencer
interface modexp_stream_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int WIDTH      = 4096
);
  logic                  go;
  logic [WIDTH-1:0]      message;
  logic [WIDTH-1:0]      exponent;
  logic [WIDTH-1:0]      modulus;
  logic [WIDTH-1:0]      r_val;
  logic [WIDTH-1:0]      t_val;
  logic [63:0]           nprime0_in;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;
  logic [WIDTH-1:0]      result;
  logic [DATA_WIDTH-1:0] m_buf;
  logic [DATA_WIDTH-1:0] e_buf;
  logic [DATA_WIDTH-1:0] n_buf;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] t_buf;
  logic [63:0]           nprime0;
  logic                  start_input;
  logic                  start_compute;
  logic                  get_result;
  logic [4:0]            exp_state;
  logic [DATA_WIDTH-1:0] res_out;

  modport slave (
    input  go, message, exponent, modulus, r_val, t_val, nprime0_in, exp_state, res_out,
    output busy, done, timeout_err, result, m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
           start_input, start_compute, get_result
  );

  modport master (
    output go, message, exponent, modulus, r_val, t_val, nprime0_in, exp_state, res_out,
    input  busy, done, timeout_err, result, m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
           start_input, start_compute, get_result
  );
endinterface

// File: rtl/modexp_stream_ctrl.sv
// rtl/modexp_stream_ctrl.sv - snapshots wide operands, streams them LS-word first to the ModExp core, collects the result
module modexp_stream_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int WIDTH         = 4096,
  parameter int COMPLETE_CODE = 9,
  parameter int RD_LAT        = 1,
  parameter int WAIT_TIMEOUT  = 2**24
) (
  input logic                 clk,
  input logic                 reset,
  modexp_stream_ctrl_if.slave bus
);
  localparam int NWORDS = WIDTH / DATA_WIDTH;
  localparam int CW     = $clog2(NWORDS + RD_LAT + 1);
  localparam int WW     = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(NWORDS - 1);
  localparam logic [CW-1:0] READ_LAST = CW'(RD_LAT + NWORDS - 1);
  localparam logic [CW-1:0] RD_SKIP   = CW'(RD_LAT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);

  if (WIDTH % DATA_WIDTH != 0) begin : g_width_check
    $error("WIDTH must be a multiple of DATA_WIDTH");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_CORE, S_READ, S_FIN} state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [WW-1:0]         wait_q;
  logic [WIDTH-1:0]      m_q, e_q, n_q, r_q, t_q;
  logic [WIDTH-1:0]      result_q;
  logic [DATA_WIDTH-1:0] m_buf_q, e_buf_q, n_buf_q, r_buf_q, t_buf_q;
  logic [63:0]           nprime0_q;
  logic                  busy_q, done_q, timeout_q;
  logic                  start_input_q, start_compute_q, get_result_q;

  // Snapshots are kept pre-shifted by one word: the word on the bus is always
  // the low slice of the register as it stood on the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      wait_q          <= '0;
      m_q             <= '0;
      e_q             <= '0;
      n_q             <= '0;
      r_q             <= '0;
      t_q             <= '0;
      result_q        <= '0;
      m_buf_q         <= '0;
      e_buf_q         <= '0;
      n_buf_q         <= '0;
      r_buf_q         <= '0;
      t_buf_q         <= '0;
      nprime0_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      start_input_q   <= 1'b0;
      start_compute_q <= 1'b0;
      get_result_q    <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      start_compute_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.go) begin
            m_q           <= bus.message >> DATA_WIDTH;
            e_q           <= bus.exponent >> DATA_WIDTH;
            n_q           <= bus.modulus >> DATA_WIDTH;
            r_q           <= bus.r_val >> DATA_WIDTH;
            t_q           <= bus.t_val >> DATA_WIDTH;
            m_buf_q       <= bus.message[DATA_WIDTH-1:0];
            e_buf_q       <= bus.exponent[DATA_WIDTH-1:0];
            n_buf_q       <= bus.modulus[DATA_WIDTH-1:0];
            r_buf_q       <= bus.r_val[DATA_WIDTH-1:0];
            t_buf_q       <= bus.t_val[DATA_WIDTH-1:0];
            nprime0_q     <= bus.nprime0_in;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
            start_input_q <= 1'b1;
            state_q       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt_q == LOAD_LAST) begin
            m_buf_q         <= '0;
            e_buf_q         <= '0;
            n_buf_q         <= '0;
            r_buf_q         <= '0;
            t_buf_q         <= '0;
            start_input_q   <= 1'b0;
            start_compute_q <= 1'b1;
            get_result_q    <= 1'b1;
            wait_q          <= '0;
            state_q         <= S_WAIT_CORE;
          end else begin
            m_buf_q <= m_q[DATA_WIDTH-1:0];
            e_buf_q <= e_q[DATA_WIDTH-1:0];
            n_buf_q <= n_q[DATA_WIDTH-1:0];
            r_buf_q <= r_q[DATA_WIDTH-1:0];
            t_buf_q <= t_q[DATA_WIDTH-1:0];
            m_q     <= m_q >> DATA_WIDTH;
            e_q     <= e_q >> DATA_WIDTH;
            n_q     <= n_q >> DATA_WIDTH;
            r_q     <= r_q >> DATA_WIDTH;
            t_q     <= t_q >> DATA_WIDTH;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_WAIT_CORE: begin
          // Completion wins over a timeout landing on the same cycle.
          if (bus.exp_state == 5'(COMPLETE_CODE)) begin
            cnt_q   <= '0;
            state_q <= S_READ;
          end else if (wait_q == WAIT_LAST) begin
            timeout_q    <= 1'b1;
            get_result_q <= 1'b0;
            busy_q       <= 1'b0;
            nprime0_q    <= '0;
            state_q      <= S_IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_READ: begin
          // Words shift in from the top so the first kept word ends up in the LS slot.
          if (cnt_q >= RD_SKIP) begin
            result_q <= {bus.res_out, result_q[WIDTH-1:DATA_WIDTH]};
          end
          if (cnt_q == READ_LAST) begin
            get_result_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= S_FIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIN: begin
          busy_q    <= 1'b0;
          nprime0_q <= '0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.timeout_err   = timeout_q;
  assign bus.result        = result_q;
  assign bus.m_buf         = m_buf_q;
  assign bus.e_buf         = e_buf_q;
  assign bus.n_buf         = n_buf_q;
  assign bus.r_buf         = r_buf_q;
  assign bus.t_buf         = t_buf_q;
  assign bus.nprime0       = nprime0_q;
  assign bus.start_input   = start_input_q;
  assign bus.start_compute = start_compute_q;
  assign bus.get_result    = get_result_q;
endmodule

// File: tb/tb_modexp_stream_ctrl.sv
// tb/tb_modexp_stream_ctrl.sv - directed bench for modexp_stream_ctrl with a behavioural ModExp core
module tb_modexp_stream_ctrl;
  localparam int DW = 64;
  localparam int W  = 4096;
  localparam int NW = W / DW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad   = 0;

  modexp_stream_ctrl_if #(.DATA_WIDTH(DW), .WIDTH(W)) bus ();

  modexp_stream_ctrl #(
    .DATA_WIDTH(DW), .WIDTH(W), .COMPLETE_CODE(9), .RD_LAT(1), .WAIT_TIMEOUT(100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Core: ready 10 cycles after start_compute, then one word per cycle with one cycle of read latency.
  logic         core_en = 1'b1;
  logic [W-1:0] core_res = '0;
  int core_cnt = 0;
  int rd_cnt   = 0;
  assign bus.exp_state = (core_en && core_cnt == 10) ? 5'd9 : 5'd0;

  always @(posedge clk) begin
    if (reset || bus.start_input) core_cnt <= 0;
    else if (bus.start_compute) core_cnt <= 1;
    else if (core_cnt != 0 && core_cnt != 10) core_cnt <= core_cnt + 1;
    if (reset || !bus.get_result) begin
      rd_cnt      <= 0;
      bus.res_out <= '0;
    end else if (bus.exp_state == 5'd9) begin
      rd_cnt      <= rd_cnt + 1;
      bus.res_out <= (rd_cnt >= 1 && rd_cnt <= NW) ? core_res[(rd_cnt-1)*DW +: DW] : '0;
    end
  end

  int done_cnt = 0, to_cnt = 0, sc_cnt = 0, gr_cnt = 0, ld_idx = 0;
  logic [DW-1:0] ld_m[NW], ld_e[NW], ld_n[NW], ld_r[NW], ld_t[NW];
  logic [63:0]   ld_np;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.timeout_err === 1'b1) to_cnt++;
    if (bus.start_compute === 1'b1) sc_cnt++;
    if (bus.get_result === 1'b1) gr_cnt++;
    if (bus.start_input === 1'b1) begin
      if (ld_idx < NW) begin
        ld_m[ld_idx] = bus.m_buf;
        ld_e[ld_idx] = bus.e_buf;
        ld_n[ld_idx] = bus.n_buf;
        ld_r[ld_idx] = bus.r_buf;
        ld_t[ld_idx] = bus.t_buf;
      end
      if (ld_idx == 0) ld_np = bus.nprime0;
      ld_idx++;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [W-1:0] pat(input logic [63:0] base, input logic [63:0] step);
    logic [W-1:0] v;
    for (int k = 0; k < NW; k++) v[k*DW +: DW] = base + step * 64'(k);
    return v;
  endfunction

  task automatic clr_mon();
    done_cnt = 0; to_cnt = 0; sc_cnt = 0; gr_cnt = 0; ld_idx = 0;
  endtask

  task automatic set_ops(input logic [W-1:0] m, e, n, r, t, input logic [63:0] np);
    bus.message = m; bus.exponent = e; bus.modulus = n;
    bus.r_val = r; bus.t_val = t; bus.nprime0_in = np;
  endtask

  task automatic pulse_go();
    @(negedge clk); bus.go = 1'b1;
    @(negedge clk); bus.go = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  logic [W-1:0] res_c, res_aa, res_55;
  bit seen;
  int ld_err;

  initial begin
    bus.go = 1'b0;
    set_ops('0, '0, '0, '0, '0, 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_start_input", bus.start_input, 0);
    chk("rst_get_result", bus.get_result, 0);
    chk("rst_m_buf", bus.m_buf, 0);
    chk("rst_nprime0", bus.nprime0, 0);
    chk("rst_result", bus.result, 0);

    // m=8, e=13, n=77 -> 50
    clr_mon();
    core_res = W'(50);
    set_ops(W'(8), W'(13), W'(77), W'(3), W'(4), 64'h1234);
    pulse_go();
    wait_done(400, seen);
    chk("a_done_seen", seen, 1);
    repeat (3) @(negedge clk);
    chk("a_result", bus.result, W'(50));
    chk("a_done_cnt", done_cnt, 1);
    chk("a_timeout_cnt", to_cnt, 0);
    chk("a_start_compute_cnt", sc_cnt, 1);
    chk("a_busy_after", bus.busy, 0);
    chk("a_word0_m", ld_m[0], 64'd8);
    chk("a_word0_n", ld_n[0], 64'd77);
    chk("a_word1_e", ld_e[1], 64'd0);
    chk("a_nprime0_held", ld_np, 64'h1234);
    chk("a_nprime0_idle", bus.nprime0, 0);

    // every word k = 0x1000+k; operands changed after the snapshot must not leak in
    clr_mon();
    core_res = pat(64'hC0DE_0000_0000_0000, 64'h1);
    set_ops(pat(64'h1000, 1), pat(64'h1000, 1), pat(64'h1000, 1), pat(64'h1000, 1), pat(64'h1000, 1), 64'h5);
    pulse_go();
    set_ops('0, '0, '0, '0, '0, 64'h0);
    wait_done(400, seen);
    chk("b_done_seen", seen, 1);
    repeat (3) @(negedge clk);
    ld_err = 0;
    for (int k = 0; k < NW; k++) begin
      if (ld_m[k] !== 64'h1000 + 64'(k) || ld_e[k] !== 64'h1000 + 64'(k) || ld_n[k] !== 64'h1000 + 64'(k) ||
          ld_r[k] !== 64'h1000 + 64'(k) || ld_t[k] !== 64'h1000 + 64'(k)) ld_err++;
    end
    chk("b_load_word_errors", ld_err, 0);
    chk("b_load_cycles", ld_idx, NW);
    chk("b_start_compute_cnt", sc_cnt, 1);
    chk("b_result", bus.result, pat(64'hC0DE_0000_0000_0000, 64'h1));

    // go toggled every cycle while busy
    clr_mon();
    res_c = pat(64'h0123_4567_89AB_0000, 64'h11);
    core_res = res_c;
    set_ops(W'(2), W'(3), W'(5), W'(1), W'(1), 64'h9);
    @(negedge clk); bus.go = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else bus.go = ~bus.go;
    end
    bus.go = 1'b0;
    chk("c_done_seen", seen, 1);
    repeat (4) @(negedge clk);
    chk("c_done_cnt", done_cnt, 1);
    chk("c_start_compute_cnt", sc_cnt, 1);
    chk("c_load_cycles", ld_idx, NW);
    chk("c_busy_after", bus.busy, 0);
    chk("c_result", bus.result, res_c);

    // core never completes
    clr_mon();
    core_en = 1'b0;
    core_res = pat(64'hDEAD, 0);
    pulse_go();
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.timeout_err === 1'b1) seen = 1'b1;
    end
    chk("d_timeout_seen", seen, 1);
    chk("d_busy", bus.busy, 0);
    chk("d_get_result", bus.get_result, 0);
    chk("d_wait_cycles", gr_cnt, 100);
    repeat (3) @(negedge clk);
    chk("d_timeout_cnt", to_cnt, 1);
    chk("d_done_cnt", done_cnt, 0);
    chk("d_result_kept", bus.result, res_c);
    core_en = 1'b1;

    // reset during LOAD cycle 30
    clr_mon();
    set_ops(pat(64'h1000, 1), pat(64'h1000, 1), pat(64'h1000, 1), pat(64'h1000, 1), pat(64'h1000, 1), 64'h7);
    pulse_go();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.start_input === 1'b1 && bus.m_buf === 64'h1000 + 64'd30) seen = 1'b1;
      else @(negedge clk);
    end
    chk("e_reached_word30", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("e_busy", bus.busy, 0);
    chk("e_start_input", bus.start_input, 0);
    chk("e_m_buf", bus.m_buf, 0);
    chk("e_nprime0", bus.nprime0, 0);
    chk("e_result", bus.result, 0);
    chk("e_done", bus.done, 0);
    chk("e_timeout", bus.timeout_err, 0);
    @(negedge clk);
    clr_mon();
    core_res = W'(16'h77);
    set_ops(W'(8), W'(13), W'(77), W'(3), W'(4), 64'h1234);
    pulse_go();
    wait_done(400, seen);
    chk("e2_done_seen", seen, 1);
    repeat (3) @(negedge clk);
    chk("e2_result", bus.result, W'(16'h77));
    chk("e2_done_cnt", done_cnt, 1);

    // back-to-back
    clr_mon();
    res_aa = pat(64'hAAAA_AAAA_AAAA_AAAA, 0);
    res_55 = pat(64'h5555_5555_5555_5555, 0);
    core_res = res_aa;
    pulse_go();
    wait_done(400, seen);
    chk("f1_done_seen", seen, 1);
    chk("f1_result", bus.result, res_aa);
    core_res = res_55;
    @(negedge clk); bus.go = 1'b1;
    @(negedge clk); bus.go = 1'b0;
    chk("f2_accepted", bus.busy, 1);
    wait_done(400, seen);
    chk("f2_done_seen", seen, 1);
    repeat (3) @(negedge clk);
    chk("f2_result", bus.result, res_55);
    chk("f2_done_cnt", done_cnt, 2);
    chk("f2_start_compute_cnt", sc_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
